// File: rtl/jtoutrun_subbus_arb_pkg.sv
// Shared types and defaults for the main-to-sub bus arbiter.
package jtoutrun_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DONE,
        ST_HOLD,
        ST_REL
    } arb_st_t;

    localparam int          SETTLE_DEF  = 2;
    localparam int          HOLD_DEF    = 8;
    localparam int          TMOW_DEF    = 10;
    localparam logic [15:0] RD_TMO_DATA = 16'hFFFF;

endpackage

// File: rtl/jtoutrun_subbus_arb_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module jtoutrun_arb_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (clr)              cnt <= '0;
        else if (inc && !(&cnt))   cnt <= cnt + ONE;
    end

endmodule

// File: rtl/jtoutrun_subbus_arb.sv
// Main-CPU access sequencer into the sub-CPU bus: request, grant wait, settle, complete, hold, release.
// Optional JTOUTRUN_ARB_STATS_EN adds grant-latency and transfer-count statistics.
module jtoutrun_subbus_arb
    import jtoutrun_arb_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF,
    parameter int HOLD   = HOLD_DEF,
    parameter int TMOW   = TMOW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        main_cs,
    input  logic        main_rnw,
    output logic        main_ok,
    output logic [15:0] main_din,
    output logic        sub_br,
    input  logic        sub_bgackn,
    input  logic        sub_ok,
    input  logic [15:0] sub_din,
    output logic        err
`ifdef JTOUTRUN_ARB_STATS_EN
    ,
    output logic [15:0] stat_lat,
    output logic [15:0] stat_acc
`endif
);

    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int HW = (HOLD   < 1) ? 1 : $clog2(HOLD + 1);

    localparam logic [SW-1:0]   SETTLE_V  = SW'(SETTLE);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    // Timeout fires on the REQ cycle that would take the counter to all-ones.
    localparam logic [TMOW-1:0] TMO_LAST  = {{(TMOW-1){1'b1}}, 1'b0};

    arb_st_t     st, st_nx;
    logic        rnw, rnw_nx;
    logic        br_nx, ok_nx, err_nx;
    logic [15:0] din_nx;

    logic            tmo_clr, tmo_inc, set_clr, set_inc, hld_clr, hld_inc;
    logic [TMOW-1:0] tmo_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [HW-1:0]   hold_cnt;

    jtoutrun_arb_cnt #(.W(TMOW)) u_tmo (
        .clk(clk), .rst_n(rst_n), .clr(tmo_clr), .inc(tmo_inc), .cnt(tmo_cnt)
    );
    jtoutrun_arb_cnt #(.W(SW)) u_settle (
        .clk(clk), .rst_n(rst_n), .clr(set_clr), .inc(set_inc), .cnt(settle_cnt)
    );
    jtoutrun_arb_cnt #(.W(HW)) u_hold (
        .clk(clk), .rst_n(rst_n), .clr(hld_clr), .inc(hld_inc), .cnt(hold_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            rnw      <= 1'b0;
            sub_br   <= 1'b0;
            main_ok  <= 1'b0;
            main_din <= 16'h0000;
            err      <= 1'b0;
        end else begin
            st       <= st_nx;
            rnw      <= rnw_nx;
            sub_br   <= br_nx;
            main_ok  <= ok_nx;
            main_din <= din_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        st_nx   = st;
        rnw_nx  = rnw;
        br_nx   = sub_br;
        ok_nx   = main_ok;
        din_nx  = main_din;
        err_nx  = err;
        tmo_clr = 1'b0;
        tmo_inc = 1'b0;
        set_clr = 1'b0;
        set_inc = 1'b0;
        hld_clr = 1'b0;
        hld_inc = 1'b0;
        // Completion is a level handshake: it falls as soon as the master lets go.
        if (!main_cs) ok_nx = 1'b0;
        case (st)
            ST_IDLE: begin
                if (main_cs && !main_ok) begin
                    st_nx   = ST_REQ;
                    br_nx   = 1'b1;
                    rnw_nx  = main_rnw;
                    tmo_clr = 1'b1;
                end
            end
            ST_REQ: begin
                if (!main_cs) begin
                    st_nx = ST_REL;
                    br_nx = 1'b0;
                end else if (!sub_bgackn) begin
                    st_nx   = ST_XFER;
                    set_clr = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    st_nx  = ST_REL;
                    br_nx  = 1'b0;
                    err_nx = 1'b1;
                    ok_nx  = 1'b1;
                    if (rnw) din_nx = RD_TMO_DATA;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            ST_XFER: begin
                if (!main_cs) begin
                    st_nx = ST_REL;
                    br_nx = 1'b0;
                end else if (sub_bgackn) begin
                    st_nx   = ST_REQ;
                    tmo_clr = 1'b1;
                end else if (settle_cnt != SETTLE_V) begin
                    set_inc = 1'b1;
                end else if (sub_ok) begin
                    st_nx = ST_DONE;
                    ok_nx = 1'b1;
                    if (rnw) din_nx = sub_din;
                end
            end
            ST_DONE: begin
                if (!main_cs) begin
                    st_nx   = ST_HOLD;
                    hld_clr = 1'b1;
                end
            end
            ST_HOLD: begin
                // A follow-on access reuses the grant we still own.
                if (main_cs) begin
                    st_nx   = ST_XFER;
                    rnw_nx  = main_rnw;
                    set_clr = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    st_nx = ST_REL;
                    br_nx = 1'b0;
                end else begin
                    hld_inc = 1'b1;
                end
            end
            ST_REL: begin
                br_nx = 1'b0;
                if (sub_bgackn) st_nx = ST_IDLE;
            end
            default: st_nx = ST_IDLE;
        endcase
    end

`ifdef JTOUTRUN_ARB_STATS_EN
    logic [15:0] lat_cnt;
    logic [15:0] lat_cand;
    logic        lat_take;
    logic        acc_take;

    jtoutrun_arb_cnt #(.W(16)) u_lat (
        .clk(clk), .rst_n(rst_n), .clr(tmo_clr), .inc(tmo_inc), .cnt(lat_cnt)
    );

    // Latency counts the grant cycle itself, so a grant seen on the first REQ cycle reads 1.
    assign lat_cand = (&lat_cnt) ? 16'hFFFF : lat_cnt + 16'd1;
    assign lat_take = (st == ST_REQ) && main_cs && !sub_bgackn;
    assign acc_take = (st == ST_XFER) && (st_nx == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lat <= 16'h0000;
            stat_acc <= 16'h0000;
        end else begin
            if (lat_take && (lat_cand > stat_lat)) stat_lat <= lat_cand;
            if (acc_take) stat_acc <= stat_acc + 16'd1;
        end
    end
`endif

endmodule
